// File: rtl/rv32_pkg.sv
// Shared RV32I encoding constants: format codes, opcode rules, immediate limits
// and the output FIFO state/entry types.
package rv32_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [1:0] OPC_LOW = 2'b11;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMMB_MIN  = -4096;
  localparam int IMMB_MAX  = 4094;
  localparam int IMMJ_MIN  = -1048576;
  localparam int IMMJ_MAX  = 1048574;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } fifo_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
  } entry_t;

endpackage

// File: rtl/imm_pack.sv
// Combinational RV32I field packer with immediate range/alignment checking.
module imm_pack
  import rv32_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] inst,
  output logic        err
);

  logic signed [31:0] simm;
  assign simm = $signed(imm);

  always_comb begin
    inst = '0;
    err  = 1'b0;
    case (fmt)
      FMT_R: inst = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        inst = {imm[11:0], rs1, funct3, rd, opcode};
        err  = (simm < IMM12_MIN) || (simm > IMM12_MAX);
      end
      FMT_S: begin
        inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err  = (simm < IMM12_MIN) || (simm > IMM12_MAX);
      end
      FMT_B: begin
        inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err  = (simm < IMMB_MIN) || (simm > IMMB_MAX) || imm[0];
      end
      FMT_U: begin
        inst = {imm[31:12], rd, opcode};
        err  = (imm[11:0] != 12'd0);
      end
      FMT_J: begin
        inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err  = (simm < IMMJ_MIN) || (simm > IMMJ_MAX) || imm[0];
      end
      default: err = 1'b1;
    endcase
    if (opcode[1:0] != OPC_LOW) err = 1'b1;
  end

endmodule

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs fields, tags each good word with an address,
// buffers results in a 2-entry FIFO and counts dropped (errored) inputs.
module inst_encoder
  import rv32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  input  logic        load_base,
  input  logic [31:0] base_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        err_sticky,
  output logic [7:0]  err_cnt,
  input  logic        err_clr
);

  fifo_state_e state_q, state_d;
  entry_t      slot0, slot1;
  logic [31:0] addr_q;
  logic        in_ready_q;
  logic [31:0] pack_inst;
  logic        pack_err;
  logic        accept, push, pop, err_ev;

  imm_pack u_pack (
    .fmt    (fmt),
    .opcode (opcode),
    .rd     (rd),
    .rs1    (rs1),
    .rs2    (rs2),
    .funct3 (funct3),
    .funct7 (funct7),
    .imm    (imm),
    .inst   (pack_inst),
    .err    (pack_err)
  );

  assign accept = in_valid & in_ready_q & ~load_base;
  assign push   = accept & ~pack_err;
  assign err_ev = accept & pack_err;
  assign pop    = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (push) state_d = ST_ONE;
      ST_ONE: begin
        if (push && !pop)      state_d = ST_TWO;
        else if (!push && pop) state_d = ST_EMPTY;
      end
      ST_TWO:  if (pop) state_d = ST_ONE;
      default: state_d = ST_EMPTY;
    endcase
  end

  // slot0 is always the head; in_ready is low in TWO so no push arrives there
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      slot0      <= '0;
      slot1      <= '0;
      addr_q     <= '0;
      in_ready_q <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_TWO);
      case (state_q)
        ST_EMPTY: if (push) slot0 <= '{inst: pack_inst, addr: addr_q};
        ST_ONE: begin
          if (push && pop) slot0 <= '{inst: pack_inst, addr: addr_q};
          else if (push)   slot1 <= '{inst: pack_inst, addr: addr_q};
        end
        ST_TWO:  if (pop) slot0 <= slot1;
        default: ;
      endcase
      if (load_base)  addr_q <= base_addr & ~32'h3;
      else if (push)  addr_q <= addr_q + 32'd4;
      if (err_ev) begin
        err_sticky <= 1'b1;
        if (err_clr)              err_cnt <= 8'd1;
        else if (err_cnt != '1)   err_cnt <= err_cnt + 8'd1;
      end else if (err_clr) begin
        err_sticky <= 1'b0;
        err_cnt    <= '0;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_inst  = slot0.inst;
  assign out_addr  = slot0.addr;

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-002 SHALL have ports: in_valid in 1, field set offered; in_ready out 1, field set accepted when in_valid & in_ready & !load_base.
REQ-003 SHALL have ports: fmt in 3, format (0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6-7 illegal); opcode in 7; rd, rs1, rs2 in 5 each; funct3 in 3; funct7 in 7; imm in 32, full signed/byte-offset value.
REQ-004 SHALL have ports: load_base in 1, load base_addr; base_addr in 32, word-aligned start address.
REQ-005 SHALL have ports: out_valid out 1; out_ready in 1; out_inst out 32, encoded word; out_addr out 32, target address.
REQ-006 SHALL have ports: err_sticky out 1; err_cnt out 8, dropped-input count; err_clr in 1.

Function
REQ-007 SHALL pack fields into standard RV32I positions; imm bits per format: I imm[11:0]->[31:20]; S imm[11:5]->[31:25], imm[4:0]->[11:7]; B imm[12|10:5|4:1|11]->[31|30:25|11:8|7]; U imm[31:12]->[31:12]; J imm[20|10:1|11|19:12]->[31|30:21|20|19:12]; R funct7->[31:25].
REQ-008 SHALL ignore fields unused by the selected format and drive their bit positions from whichever fields that format does use.
REQ-009 SHALL flag an accepted input as error when: fmt illegal; opcode[1:0] != 2'b11; I/S imm outside -2048..2047; B imm outside -4096..4094 or imm[0]=1; J imm outside -1048576..1048574 or imm[0]=1; U imm[11:0] != 0.
REQ-010 SHALL drop errored inputs (no output, no address increment), set err_sticky, and increment err_cnt, saturating at 255.
REQ-011 err_clr SHALL zero err_sticky and err_cnt next cycle; an error in the same cycle as err_clr SHALL win (sticky=1, cnt=1).
REQ-012 SHALL buffer outputs in a 2-entry FIFO with states EMPTY, ONE, TWO.
REQ-013 in_ready SHALL be registered and SHALL equal (state != TWO), independent of out_ready.
REQ-014 An accepted good input SHALL appear on out_inst/out_addr at earliest the next cycle (latency 1); order SHALL be preserved.
REQ-015 out_valid SHALL equal (state != EMPTY); output SHALL pop on out_valid & out_ready; out_inst/out_addr SHALL hold stable while out_valid & !out_ready.
REQ-016 In ONE, a simultaneous push and pop SHALL remain in ONE; push only -> TWO; pop only -> EMPTY. In TWO, pop -> ONE. In EMPTY, push -> ONE.
REQ-017 An address counter SHALL tag each good input with its current value, then add 4; it SHALL wrap from 0xFFFFFFFC to 0.
REQ-018 load_base SHALL set the counter to {base_addr[31:2],2'b00}, SHALL block acceptance that cycle, and SHALL NOT disturb buffered entries.

Reset
REQ-019 On rst: state EMPTY, out_valid 0, in_ready 0 during the reset cycle and 1 after, out_inst 0, out_addr 0, counter 0, err_sticky 0, err_cnt 0.
REQ-020 Reset mid-operation SHALL discard buffered entries without emitting them.

Structure
REQ-021 Format codes, opcode constants and the immediate range limits SHALL live in shared package rv32_pkg.
REQ-022 Packing and range checking SHALL be a combinational sub-module imm_pack (fields in -> inst, err out); inst_encoder owns the FIFO, FSM, counter and error counters.

Verification
REQ-023 Base 0x100, I, opcode 0x13, rd 1, rs1 0, funct3 0, imm 0xFFFFFFFF -> out_inst 0xFFF00093, out_addr 0x100, one cycle later.
REQ-024 B, opcode 0x63, rs1 0, rs2 0, funct3 0, imm 0xFFFFFFFC -> 0xFE000EE3; then J, opcode 0x6F, rd 1, imm 0x800 -> 0x001000EF, addr +4.
REQ-025 I, imm 2048 -> no out_valid, err_sticky 1, err_cnt 1, counter unchanged; then err_clr -> 0/0.
REQ-026 out_ready 0, offer 3 inputs back-to-back -> 2 accepted, in_ready 0; raise out_ready -> entries emitted in order at addrs base and base+4; third accepted after the first pop.
REQ-027 State TWO with counter 0xFFFFFFFC, assert rst -> out_valid 0 next cycle, nothing emitted; new input lands at addr 0.
REQ-028 256 consecutive errored inputs -> err_cnt holds 255.
